// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and data-memory signal bundle for dmem_arbiter
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req0, req1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1;
    logic              done0, done1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              busy;
    logic              mem_en, mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, done0, done1, rdata0, rdata1, busy,
               mem_en, mem_wen, mem_addr, mem_wdata
    );

    // Requesters plus memory side
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, done0, done1, rdata0, rdata1, busy,
               mem_en, mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter onto a single-port data memory
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RDATA, DONE} state_e;

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        // The pointer only matters on a tie; a sole requester always wins.
        win      = (bus.req0 && bus.req1) ? ptr_q : bus.req1;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    owner_d = win;
                    ptr_d   = ~win;
                    we_d    = win ? bus.we1    : bus.we0;
                    addr_d  = win ? bus.addr1  : bus.addr0;
                    wdata_d = win ? bus.wdata1 : bus.wdata0;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = we_q ? DONE : RDATA;
            RDATA: begin
                // Memory output is registered, so it is valid during this state.
                if (owner_q) rdata1_d = bus.mem_rdata;
                else         rdata0_d = bus.mem_rdata;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.gnt0      = (state_q == ISSUE) && !owner_q;
    assign bus.gnt1      = (state_q == ISSUE) &&  owner_q;
    assign bus.done0     = (state_q == DONE)  && !owner_q;
    assign bus.done1     = (state_q == DONE)  &&  owner_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.mem_en    = (state_q == ISSUE);
    assign bus.mem_wen   = (state_q == ISSUE) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_wen) mem[bus.mem_addr] <= bus.mem_wdata;
            else             bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    int edge_n = 0;

    // Transaction-level reference: one outstanding transfer with a start edge.
    bit          m_active = 0;
    int          m_start = 0;
    bit          m_ptr = 0;
    bit          m_owner = 0;
    bit          m_we = 0;
    logic [7:0]  m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata [2];
    logic [31:0] m_mem [256];

    int gq[$];
    int geq[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s edge=%0d actual=%0h expected=%0h", tag, edge_n, act, exp);
        end
    endtask

    task automatic model_step();
        int len;
        bit w;
        if (rst_n) begin
            len = m_we ? 2 : 3;
            if (m_active) begin
                if (edge_n == m_start + 1 && m_we)  m_mem[m_addr] = m_wdata;
                if (edge_n == m_start + 2 && !m_we) m_rdata[m_owner] = m_mem[m_addr];
                if (edge_n - 1 - m_start >= len)    m_active = 0;
            end
            if (!m_active && (bus.req0 || bus.req1)) begin
                w        = (bus.req0 && bus.req1) ? m_ptr : bus.req1;
                m_ptr    = !w;
                m_owner  = w;
                m_we     = w ? bus.we1 : bus.we0;
                m_addr   = w ? bus.addr1 : bus.addr0;
                m_wdata  = w ? bus.wdata1 : bus.wdata0;
                m_start  = edge_n;
                m_active = 1;
            end
        end
    endtask

    task automatic check_cycle();
        int len;
        int ph;
        bit act;
        len = m_we ? 2 : 3;
        ph  = edge_n - m_start;
        act = m_active && ph < len;
        chk("busy",      bus.busy,      act);
        chk("gnt0",      bus.gnt0,      act && ph == 0 && !m_owner);
        chk("gnt1",      bus.gnt1,      act && ph == 0 &&  m_owner);
        chk("done0",     bus.done0,     act && ph == len - 1 && !m_owner);
        chk("done1",     bus.done1,     act && ph == len - 1 &&  m_owner);
        chk("mem_en",    bus.mem_en,    act && ph == 0);
        chk("mem_wen",   bus.mem_wen,   act && ph == 0 && m_we);
        chk("mem_addr",  bus.mem_addr,  m_addr);
        chk("mem_wdata", bus.mem_wdata, m_wdata);
        chk("rdata0",    bus.rdata0,    m_rdata[0]);
        chk("rdata1",    bus.rdata1,    m_rdata[1]);
        if (bus.gnt0) begin gq.push_back(0); geq.push_back(edge_n); end
        if (bus.gnt1) begin gq.push_back(1); geq.push_back(edge_n); end
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        model_step();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_busy",   bus.busy,   0);
        chk("rst_gnt",    {bus.gnt0, bus.gnt1, bus.done0, bus.done1}, 0);
        chk("rst_rdata",  {bus.rdata0, bus.rdata1}, 0);
        m_active = 0; m_ptr = 0; m_owner = 0; m_we = 0;
        m_addr = '0; m_wdata = '0;
        m_rdata[0] = '0; m_rdata[1] = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic idle_inputs();
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin mem[i] = '0; m_mem[i] = '0; end
        m_rdata[0] = '0; m_rdata[1] = '0;
        bus.mem_rdata = '0;
        idle_inputs();
        #2;
        do_reset();

        // Port 0 single write
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h10; bus.wdata0 = 32'hDEADBEEF;
        step();
        chk("wr_gnt0", bus.gnt0, 1);
        chk("wr_mem_addr", bus.mem_addr, 8'h10);
        chk("wr_mem_wen", bus.mem_wen, 1);
        bus.req0 = 0;
        step();
        chk("wr_done0", bus.done0, 1);
        chk("wr_rdata0", bus.rdata0, 0);
        step();

        // Port 1 read-back
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h10;
        step();
        chk("rd_wen", bus.mem_wen, 0);
        bus.req1 = 0;
        step();
        step();
        chk("rd_done1", bus.done1, 1);
        chk("rd_rdata1", bus.rdata1, 32'hDEADBEEF);
        step();

        // Simultaneous held reads after reset alternate starting with port 0
        do_reset();
        bus.req0 = 1; bus.req1 = 1; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = 8'h10; bus.addr1 = 8'h10;
        gq.delete(); geq.delete();
        repeat (24) step();
        idle_inputs();
        repeat (4) step();
        chk("rr_count", gq.size(), 6);
        for (int i = 0; i < gq.size(); i++) chk("rr_order", gq[i], i % 2);

        // Held request from port 0 alone: reads every 4, writes every 3
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h10;
        gq.delete(); geq.delete();
        repeat (12) step();
        bus.req0 = 0;
        repeat (4) step();
        chk("hold_rd_count", gq.size(), 3);
        for (int i = 1; i < geq.size(); i++) chk("hold_rd_gap", geq[i] - geq[i-1], 4);
        bus.req0 = 1; bus.we0 = 1; bus.wdata0 = 32'hDEADBEEF;
        gq.delete(); geq.delete();
        repeat (12) step();
        bus.req0 = 0;
        repeat (4) step();
        chk("hold_wr_count", gq.size(), 4);
        for (int i = 1; i < geq.size(); i++) chk("hold_wr_gap", geq[i] - geq[i-1], 3);

        // Reset in RDATA abandons the read; reset in ISSUE drops mem_en at once
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h10;
        step();
        bus.req0 = 0;
        step();
        chk("rdata_busy", bus.busy, 1);
        do_reset();
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h30; bus.wdata0 = 32'h12345678;
        step();
        chk("issue_mem_en", bus.mem_en, 1);
        bus.req0 = 0;
        do_reset();
        bus.req0 = 1; bus.req1 = 1; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = 8'h30; bus.addr1 = 8'h10;
        step();
        chk("post_rst_pref0", bus.gnt0, 1);
        idle_inputs();
        repeat (4) step();

        // Input change after grant must not disturb latched fields
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h20; bus.wdata0 = 32'hA5A5A5A5;
        step();
        bus.req0 = 0; bus.addr0 = 8'h55; bus.wdata0 = 32'h0;
        step();
        chk("latch_addr_done", bus.mem_addr, 8'h20);
        step();
        chk("latch_addr_idle", bus.mem_addr, 8'h20);

        // Random traffic on a small address window to get read-after-write hits
        repeat (600) begin
            bus.req0   = ($urandom_range(0, 3) != 0);
            bus.req1   = ($urandom_range(0, 2) != 0);
            bus.we0    = $urandom_range(0, 1);
            bus.we1    = $urandom_range(0, 1);
            bus.addr0  = 8'($urandom_range(0, 7));
            bus.addr1  = 8'($urandom_range(0, 7));
            bus.wdata0 = $urandom;
            bus.wdata1 = $urandom;
            step();
        end
        idle_inputs();
        repeat (6) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 8, memory word address width; DATA_W, default 32, memory data width.
REQ-002 Port clk SHALL be: input, 1 bit, single clock; all state updates on its rising edge.
REQ-003 Port rst_n SHALL be: input, 1 bit, reset, asynchronous and active-low.
REQ-004 Ports req0, req1 SHALL be: input, 1 bit each, level access request from requester 0 and requester 1.
REQ-005 Ports we0, we1 SHALL be: input, 1 bit each, 1 = write, 0 = read.
REQ-006 Ports addr0, addr1 SHALL be: input, ADDR_W each, word address.
REQ-007 Ports wdata0, wdata1 SHALL be: input, DATA_W each, write data.
REQ-008 Ports gnt0, gnt1 SHALL be: output, 1 bit each, one-cycle grant pulse.
REQ-009 Ports done0, done1 SHALL be: output, 1 bit each, one-cycle completion pulse.
REQ-010 Ports rdata0, rdata1 SHALL be: output, DATA_W each, registered read result.
REQ-011 Port busy SHALL be: output, 1 bit, high in any state other than IDLE.
REQ-012 Ports mem_en, mem_wen, mem_addr, mem_wdata SHALL be: output, 1/1/ADDR_W/DATA_W bits, drive the data memory enable, write enable, address and write data.
REQ-013 Port mem_rdata SHALL be: input, DATA_W, data memory output, registered by the memory one clk after a read is issued.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, ISSUE, RDATA and DONE.
REQ-015 IDLE SHALL behave as follows:
- if req0 or req1 is sampled high, latch the winner id, its we, addr and wdata, then go to ISSUE;
- otherwise stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: the 1-bit pointer names the preferred port, a sole requester always wins, and after each grant the pointer is set to the other port.
REQ-017 ISSUE SHALL:
- drive mem_en=1, mem_wen=latched we, mem_addr=latched addr, mem_wdata=latched wdata;
- assert gnt of the owner for exactly this cycle;
- go to DONE for a write, to RDATA for a read.
REQ-018 In states other than ISSUE, mem_en and mem_wen SHALL be 0; mem_addr and mem_wdata SHALL hold their latched values.
REQ-019 RDATA SHALL capture mem_rdata into the owner's rdata register at the exiting edge, then go to DONE.
REQ-020 DONE SHALL assert the owner's done for exactly this cycle, then go to IDLE.
REQ-021 Latency SHALL be measured from the edge that samples req in IDLE: gnt 1 cycle later; done 2 cycles later for a write, 3 cycles later for a read; rdata valid from the done cycle onward.
REQ-022 rdata0 and rdata1 SHALL hold their value until the next read completes on that port; a write SHALL NOT change them.
REQ-023 Requests SHALL be sampled only in IDLE; req high in ISSUE, RDATA or DONE SHALL be ignored.
REQ-024 A requester that holds req high after done SHALL receive a further transaction, subject to round-robin order.
REQ-025 At most one of gnt0/gnt1 SHALL be high in any cycle, and at most one of done0/done1.
REQ-026 Back-to-back transactions SHALL always pass through IDLE, giving a minimum of 3 cycles per write and 4 per read.
REQ-027 The latched request fields SHALL NOT change from IDLE exit until the return to IDLE, even if the requester's inputs change.

Reset
REQ-028 While rst_n=0, the block SHALL hold: state=IDLE, pointer=0, latched fields=0, rdata0=rdata1=0, and all outputs 0; mem_en=0 SHALL take effect immediately, without waiting for a clock edge.
REQ-029 Reset asserted mid-transaction SHALL abandon it with no gnt or done; a write whose ISSUE edge occurred before reset SHALL be considered performed.
REQ-030 After rst_n deasserts, the first arbitration SHALL prefer port 0.

Verification
REQ-031 The bench SHALL cover the following scenarios:
- Port 0 single write: addr0=0x10, wdata0=0xDEADBEEF, we0=1 -> gnt0 at cycle+1 with mem_en=1, mem_wen=1, mem_addr=0x10; done0 at cycle+2; rdata0 unchanged.
- Port 1 read-back: port 1 reads 0x10 -> done1 at cycle+3 with rdata1=0xDEADBEEF; mem_wen=0 throughout.
- Simultaneous requests after reset: both ports hold req for two reads -> grant order 0, 1; a third request from each -> grant order continues 0, 1.
- Held request: req0 held high with req1 low -> consecutive port 0 grants every 4 cycles for reads and every 3 cycles for writes.
- Reset mid-operation: rst_n=0 in RDATA -> mem_en=0 immediately, no done; after release state is IDLE, rdata=0, port 0 preferred.
- Input change after grant: addr0 changed during ISSUE -> mem_addr keeps the latched value through DONE.
